// File: rtl/data_mem_hs_pkg.sv
// Shared types and helpers for the handshaked data memory and its load extender.
package dmem_pkg;

  typedef enum logic [1:0] {
    MW_B = 2'd0,
    MW_H = 2'd1,
    MW_W = 2'd2,
    MW_D = 2'd3
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int unsigned MAX_BYTES = 8;

  function automatic logic [3:0] width_bytes(mem_width_e w);
    return 4'd1 << w;
  endfunction

  // Low address bits that must be zero for an access of width w to be aligned.
  function automatic logic [2:0] align_mask(mem_width_e w);
    return 3'(width_bytes(w) - 4'd1);
  endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response valid-ready channels between a requester (master) and data_mem_hs (slave).
import dmem_pkg::*;

interface data_mem_hs_if #(
  parameter int REG_WIDTH = 64
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic                 req_sign;
  mem_width_e           req_width;
  logic [REG_WIDTH-1:0] req_addr;
  logic [REG_WIDTH-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [REG_WIDTH-1:0] rsp_rdata;
  logic                 rsp_fault;
  logic                 rsp_write;

  modport master (
    output req_valid, req_write, req_sign, req_width, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_write
  );

  modport slave (
    input  req_valid, req_write, req_sign, req_width, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_write
  );
endinterface

// File: rtl/data_mem_hs_load_ext.sv
// Selects the low 1/2/4/8 bytes of a little-endian gathered word and sign/zero extends them.
module dmem_load_ext
  import dmem_pkg::*;
#(
  parameter int REG_WIDTH = 64
) (
  input  logic [REG_WIDTH-1:0] i_raw,
  input  mem_width_e           i_width,
  input  logic                 i_unsigned,
  output logic [REG_WIDTH-1:0] o_data
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves o_data unassigned (no latch).
    o_data = i_raw;
    case (i_width)
      MW_B: o_data = {{(REG_WIDTH-8){~i_unsigned & i_raw[7]}}, i_raw[7:0]};
      MW_H: o_data = {{(REG_WIDTH-16){~i_unsigned & i_raw[15]}}, i_raw[15:0]};
      MW_W: o_data = {{(REG_WIDTH-32){~i_unsigned & i_raw[31]}}, i_raw[31:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressed data RAM with valid/ready request and response channels, configurable
// read latency and fault reporting for out-of-range or misaligned accesses.
module data_mem_hs
  import dmem_pkg::*;
#(
  parameter int REG_WIDTH     = 64,
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 1,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input logic          clk,
  input logic          rst,
  data_mem_hs_if.slave bus
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] r_mem [MEM_DEPTH];

  dmem_state_e          r_state;
  logic [1:0]           r_cnt;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic                 r_rsp_fault;
  logic                 r_rsp_write;
  logic [REG_WIDTH-1:0] r_rsp_rdata;
  logic [REG_WIDTH-1:0] r_raw;
  mem_width_e           r_width;
  logic                 r_sign;
  logic                 r_write;
  logic                 r_fault;

  logic                  w_accept;
  logic                  w_range_fault;
  logic                  w_misalign;
  logic                  w_fault;
  logic [3:0]            w_nbytes;
  logic [ADDR_WIDTH-1:0] w_idx [MAX_BYTES];
  logic [REG_WIDTH-1:0]  w_ext;

  assign w_accept      = bus.req_valid & r_req_ready & ~rst;
  assign w_range_fault = |bus.req_addr[REG_WIDTH-1:ADDR_WIDTH];
  assign w_misalign    = MISALIGN_TRAP && ((bus.req_addr[2:0] & align_mask(bus.req_width)) != 3'd0);
  assign w_fault       = w_range_fault | w_misalign;
  assign w_nbytes      = width_bytes(bus.req_width);

  // Byte lanes wrap modulo MEM_DEPTH; aligned accesses never reach the wrap.
  always_comb begin
    for (int i = 0; i < MAX_BYTES; i++) begin
      w_idx[i] = bus.req_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
    end
  end

  // NOTE: the array and its read holding register carry no reset; contents survive rst by design.
  always_ff @(posedge clk) begin
    if (w_accept && !w_fault) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        if (bus.req_write && (4'(i) < w_nbytes)) begin
          r_mem[w_idx[i]] <= bus.req_wdata[8*i +: 8];
        end
        r_raw[8*i +: 8] <= r_mem[w_idx[i]];
      end
    end
  end

  dmem_load_ext #(
    .REG_WIDTH (REG_WIDTH)
  ) u_load_ext (
    .i_raw      (r_raw),
    .i_width    (r_width),
    .i_unsigned (r_sign),
    .o_data     (w_ext)
  );

  // NOTE: all state here is updated with <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
      r_rsp_write <= 1'b0;
      r_width     <= MW_B;
      r_sign      <= 1'b0;
      r_write     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= WAIT;
            r_cnt       <= 2'(READ_LATENCY - 1);
            r_req_ready <= 1'b0;
            r_width     <= bus.req_width;
            r_sign      <= bus.req_sign;
            r_write     <= bus.req_write;
            r_fault     <= w_fault;
          end
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (r_fault | r_write) ? '0 : w_ext;
            r_rsp_fault <= r_fault;
            r_rsp_write <= r_write;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
            r_rsp_write <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.rsp_write = r_rsp_write;

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench: two instances (latency 3 with trap, latency 1 bytewise wrap) driven from a
// vector table plus hand-written hold and mid-transaction reset sequences, checked via a scoreboard.
module tb_data_mem_hs;
  import dmem_pkg::*;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_hs_if #(.REG_WIDTH(64)) a_if ();
  data_mem_hs_if #(.REG_WIDTH(64)) b_if ();

  data_mem_hs #(
    .REG_WIDTH(64), .ADDR_WIDTH(10), .READ_LATENCY(LAT_A), .MISALIGN_TRAP(1'b1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  data_mem_hs #(
    .REG_WIDTH(64), .ADDR_WIDTH(10), .READ_LATENCY(LAT_B), .MISALIGN_TRAP(1'b0)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // Per-instance drive/observe bundles so tasks can address either DUT by index.
  logic [1:0]       d_valid, d_write, d_sign, d_rsp_ready;
  logic [1:0][1:0]  d_width;
  logic [1:0][63:0] d_addr, d_wdata;
  logic [1:0]       o_req_ready, o_rsp_valid, o_fault, o_write;
  logic [1:0][63:0] o_rdata;

  assign a_if.req_valid = d_valid[0];
  assign a_if.req_write = d_write[0];
  assign a_if.req_sign  = d_sign[0];
  assign a_if.req_width = mem_width_e'(d_width[0]);
  assign a_if.req_addr  = d_addr[0];
  assign a_if.req_wdata = d_wdata[0];
  assign a_if.rsp_ready = d_rsp_ready[0];
  assign b_if.req_valid = d_valid[1];
  assign b_if.req_write = d_write[1];
  assign b_if.req_sign  = d_sign[1];
  assign b_if.req_width = mem_width_e'(d_width[1]);
  assign b_if.req_addr  = d_addr[1];
  assign b_if.req_wdata = d_wdata[1];
  assign b_if.rsp_ready = d_rsp_ready[1];

  assign o_req_ready[0] = a_if.req_ready;
  assign o_rsp_valid[0] = a_if.rsp_valid;
  assign o_fault[0]     = a_if.rsp_fault;
  assign o_write[0]     = a_if.rsp_write;
  assign o_rdata[0]     = a_if.rsp_rdata;
  assign o_req_ready[1] = b_if.req_ready;
  assign o_rsp_valid[1] = b_if.rsp_valid;
  assign o_fault[1]     = b_if.rsp_fault;
  assign o_write[1]     = b_if.rsp_write;
  assign o_rdata[1]     = b_if.rsp_rdata;

  typedef struct {
    int          sel;
    logic        wr;
    logic        sgn;
    logic [1:0]  width;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    logic        write;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input int sel, input logic wr, input logic sgn, input logic [1:0] width,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] exp_rdata, input logic exp_fault);
    vecs.push_back('{sel, wr, sgn, width, addr, wdata, exp_rdata, exp_fault});
  endfunction

  // One full transaction: issue, measure latency, optionally stall the response, then consume it.
  task automatic run_txn(input string name, input int sel, input logic wr, input logic sgn,
                         input logic [1:0] width, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_fault, input int hold);
    int   t;
    int   lat;
    exp_t e;
    @(negedge clk);
    d_write[sel] = wr;
    d_sign[sel]  = sgn;
    d_width[sel] = width;
    d_addr[sel]  = addr;
    d_wdata[sel] = wdata;
    d_valid[sel] = 1'b1;
    t = 0;
    while (!o_req_ready[sel] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, " req_ready idle"}, 64'(o_req_ready[sel]), 64'd1);
    if (!o_req_ready[sel]) begin
      d_valid[sel] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    d_valid[sel] = 1'b0;
    sb_q.push_back('{exp_rdata, exp_fault, wr});
    check({name, " req_ready busy"}, 64'(o_req_ready[sel]), 64'd0);
    lat = 0;
    while (!o_rsp_valid[sel] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'((sel == 0) ? LAT_A : LAT_B));
    e = sb_q.pop_front();
    if (!o_rsp_valid[sel]) return;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({name, " hold rsp_valid"}, 64'(o_rsp_valid[sel]), 64'd1);
      check({name, " hold req_ready"}, 64'(o_req_ready[sel]), 64'd0);
      check({name, " hold rdata"}, o_rdata[sel], e.rdata);
    end
    @(negedge clk);
    d_rsp_ready[sel] = 1'b1;
    check({name, " rdata"}, o_rdata[sel], e.rdata);
    check({name, " fault"}, 64'(o_fault[sel]), 64'(e.fault));
    check({name, " write"}, 64'(o_write[sel]), 64'(e.write));
    @(posedge clk);
    #1;
    d_rsp_ready[sel] = 1'b0;
    check({name, " rsp_valid drop"}, 64'(o_rsp_valid[sel]), 64'd0);
    check({name, " req_ready back"}, 64'(o_req_ready[sel]), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    d_valid = '0; d_write = '0; d_sign = '0; d_rsp_ready = '0;
    d_width = '0; d_addr = '0; d_wdata = '0;

    // Instance 0: latency 3, misaligned traps. Instance 1: latency 1, bytewise wrap.
    add(0, 1, 0, 2'd3, 64'h10,  64'h8877665544332211, 64'h0, 0);
    add(0, 0, 0, 2'd0, 64'h17,  64'h0, 64'hFFFFFFFFFFFFFF88, 0);
    add(0, 0, 1, 2'd0, 64'h17,  64'h0, 64'h0000000000000088, 0);
    add(0, 0, 0, 2'd3, 64'h10,  64'h0, 64'h8877665544332211, 0);
    add(0, 0, 0, 2'd1, 64'h12,  64'h0, 64'h0000000000004433, 0);
    add(0, 0, 0, 2'd2, 64'h14,  64'h0, 64'hFFFFFFFF88776655, 0);
    add(0, 0, 1, 2'd2, 64'h14,  64'h0, 64'h0000000088776655, 0);
    add(0, 1, 0, 2'd3, 64'h20,  64'h0123456789ABCDEF, 64'h0, 0);
    add(0, 1, 0, 2'd2, 64'h22,  64'h00000000DEADBEEF, 64'h0, 1);
    add(0, 0, 0, 2'd3, 64'h20,  64'h0, 64'h0123456789ABCDEF, 0);
    add(0, 0, 0, 2'd3, 64'h400, 64'h0, 64'h0, 1);
    add(0, 0, 0, 2'd1, 64'h11,  64'h0, 64'h0, 1);
    add(0, 1, 0, 2'd0, 64'h3FF, 64'h5A, 64'h0, 0);
    add(0, 0, 1, 2'd0, 64'h3FF, 64'h0, 64'h5A, 0);
    add(0, 0, 0, 2'd0, 64'h8000000000000010, 64'h0, 64'h0, 1);
    add(1, 1, 0, 2'd1, 64'h3FF, 64'hBEEF, 64'h0, 0);
    add(1, 0, 0, 2'd1, 64'h3FF, 64'h0, 64'hFFFFFFFFFFFFBEEF, 0);
    add(1, 0, 1, 2'd0, 64'h000, 64'h0, 64'h00000000000000BE, 0);
    add(1, 0, 1, 2'd0, 64'h3FF, 64'h0, 64'h00000000000000EF, 0);
    add(1, 0, 0, 2'd3, 64'h400, 64'h0, 64'h0, 1);
    add(1, 1, 0, 2'd3, 64'h3FC, 64'h1122334455667788, 64'h0, 0);
    add(1, 0, 1, 2'd2, 64'h3FE, 64'h0, 64'h0000000033445566, 0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d req_ready", s), 64'(o_req_ready[s]), 64'd1);
      check($sformatf("reset%0d rsp_valid", s), 64'(o_rsp_valid[s]), 64'd0);
      check($sformatf("reset%0d rdata", s), o_rdata[s], 64'd0);
      check($sformatf("reset%0d fault", s), 64'(o_fault[s]), 64'd0);
      check($sformatf("reset%0d write", s), 64'(o_write[s]), 64'd0);
    end

    foreach (vecs[i]) begin
      run_txn($sformatf("v%0d", i), vecs[i].sel, vecs[i].wr, vecs[i].sgn, vecs[i].width,
              vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_fault, 0);
    end

    // Stalled consumer: response must hold for five cycles with req_ready low.
    run_txn("hold5", 0, 0, 0, 2'd3, 64'h10, 64'h0, 64'h8877665544332211, 0, 5);

    // Reset during WAIT after a store: no response, but the store stays committed.
    @(negedge clk);
    d_write[0] = 1'b1; d_sign[0] = 1'b0; d_width[0] = 2'd3;
    d_addr[0]  = 64'h40; d_wdata[0] = 64'hCAFEF00D12345678;
    d_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    d_valid[0] = 1'b0;
    check("rstwait busy", 64'(o_req_ready[0]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstwait req_ready", 64'(o_req_ready[0]), 64'd1);
    for (int k = 0; k < LAT_A + 2; k++) begin
      check($sformatf("rstwait no_rsp%0d", k), 64'(o_rsp_valid[0]), 64'd0);
      @(posedge clk);
      #1;
    end
    run_txn("rstwait load", 0, 0, 0, 2'd3, 64'h40, 64'h0, 64'hCAFEF00D12345678, 0, 0);

    check("scoreboard empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
